// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner: column scan, frame debounce, valid/ack handshake.
// Accepted nibbles shift into data_byte for processor input port i0.
module hex_keypad_scanner #(
  parameter int SCAN_TICKS      = 120_000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] col_drive,
  input  logic [3:0] row_sense,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic [7:0] data_byte,
  output logic       overflow
);

  localparam int CW = $clog2(SCAN_TICKS);
  localparam logic [CW-1:0] LAST = CW'(SCAN_TICKS - 1);
  localparam logic [4:0] DF = 5'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    HELD,
    RELEASE
  } state_t;

  state_t        state;
  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [CW-1:0] slot_cnt;
  logic [1:0]    col_idx;
  logic [15:0]   acc;
  logic [15:0]   frame_bits;
  logic [3:0]    dc;
  logic [3:0]    cand_k;
  logic [3:0]    hit_idx;
  logic [3:0]    hit_key;
  logic [4:0]    n_down;
  logic [4:0]    dc_nxt;
  logic          slot_end;
  logic          frame_end;
  logic          one_key;
  logic          no_key;
  logic          same_key;
  logic          dc_done;
  logic          accept;

  function automatic logic [3:0] key_map(input logic [3:0] idx);
    logic [3:0] k;
    k = 4'h0;
    unique case (idx)
      4'd0:  k = 4'h1;
      4'd1:  k = 4'h2;
      4'd2:  k = 4'h3;
      4'd3:  k = 4'hA;
      4'd4:  k = 4'h4;
      4'd5:  k = 4'h5;
      4'd6:  k = 4'h6;
      4'd7:  k = 4'hB;
      4'd8:  k = 4'h7;
      4'd9:  k = 4'h8;
      4'd10: k = 4'h9;
      4'd11: k = 4'hC;
      4'd12: k = 4'hE;
      4'd13: k = 4'h0;
      4'd14: k = 4'hF;
      4'd15: k = 4'hD;
    endcase
    return k;
  endfunction

  assign slot_end  = (slot_cnt == LAST);
  assign frame_end = slot_end && (col_idx == 2'd3);

  // Frame view: columns 0..2 from the accumulator, column 3 live.
  always_comb begin
    frame_bits = acc;
    for (int r = 0; r < 4; r++)
      frame_bits[r*4+3] = ~sync2[r];
  end

  always_comb begin
    n_down  = 5'd0;
    hit_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (frame_bits[i]) begin
        n_down  = n_down + 5'd1;
        hit_idx = 4'(i);
      end
    end
  end

  assign one_key  = (n_down == 5'd1);
  assign no_key   = (n_down == 5'd0);
  assign hit_key  = key_map(hit_idx);
  assign same_key = (hit_key == cand_k);
  assign dc_nxt   = {1'b0, dc} + 5'd1;
  assign dc_done  = (dc_nxt >= DF);

  always_comb begin
    accept = 1'b0;
    if (frame_end && one_key) begin
      unique case (1'b1)
        state == IDLE:  accept = (DF == 5'd1);
        state == PRESS: accept = same_key && dc_done;
        default:        accept = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1     <= 4'b1111;
      sync2     <= 4'b1111;
      slot_cnt  <= '0;
      col_idx   <= 2'd0;
      col_drive <= 4'b1110;
      acc       <= '0;
      state     <= IDLE;
      dc        <= 4'd0;
      cand_k    <= 4'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      data_byte <= 8'h00;
      overflow  <= 1'b0;
    end else begin
      sync1 <= row_sense;
      sync2 <= sync1;

      if (slot_end) begin
        slot_cnt  <= '0;
        col_idx   <= col_idx + 2'd1;
        col_drive <= {col_drive[2:0], col_drive[3]};
        if (frame_end)
          acc <= '0;
        else
          for (int r = 0; r < 4; r++)
            acc[r*4+int'(col_idx)] <= ~sync2[r];
      end else begin
        slot_cnt <= slot_cnt + CW'(1);
      end

      if (frame_end) begin
        unique case (state)
          IDLE:
            if (one_key) begin
              cand_k <= hit_key;
              dc     <= 4'd1;
              state  <= (DF == 5'd1) ? HELD : PRESS;
            end
          PRESS:
            if (!one_key) begin
              state <= IDLE;
            end else if (!same_key) begin
              cand_k <= hit_key;
              dc     <= 4'd1;
            end else if (dc_done) begin
              state <= HELD;
            end else begin
              dc <= dc_nxt[3:0];
            end
          HELD:
            if (no_key) begin
              dc    <= 4'd1;
              state <= (DF == 5'd1) ? IDLE : RELEASE;
            end
          RELEASE:
            if (!no_key)
              state <= HELD;
            else if (dc_done)
              state <= IDLE;
            else
              dc <= dc_nxt[3:0];
        endcase
      end

      // An ack landing with a new key consumes the old one.
      if (accept) begin
        key_code  <= hit_key;
        data_byte <= {data_byte[3:0], hit_key};
        key_valid <= 1'b1;
        if (key_valid && !key_ack)
          overflow <= 1'b1;
        else if (key_valid)
          overflow <= 1'b0;
      end else if (key_ack && key_valid) begin
        key_valid <= 1'b0;
        overflow  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Directed bench for hex_keypad_scanner with a passive 4x4 keypad model.
// SCAN_TICKS=8, DEBOUNCE_FRAMES=3: one frame is 32 clocks.
module tb_hex_keypad_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        key_ack = 1'b0;
  logic [3:0]  col_drive;
  logic [3:0]  row_sense;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        overflow;
  logic [7:0]  data_byte;
  logic [15:0] pressed = '0;
  logic [3:0]  exp_col;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;

  hex_keypad_scanner #(
    .SCAN_TICKS(8),
    .DEBOUNCE_FRAMES(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .col_drive(col_drive),
    .row_sense(row_sense),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_ack(key_ack),
    .data_byte(data_byte),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Key (r,c) shorts row r to column c.
  always_comb begin
    row_sense = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_drive[c])
          row_sense[r] = 1'b0;
  end

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic next_frames(input int n);
    int target;
    target = (cyc / 32 + n) * 32;
    while (cyc < target) tick();
  endtask

  task automatic ack();
    key_ack = 1'b1;
    tick();
    key_ack = 1'b0;
  endtask

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag,
                         input logic [3:0] code,
                         input logic vld,
                         input logic [7:0] dat,
                         input logic ovf);
    chk({tag, ".key_code"}, {4'h0, key_code}, {4'h0, code});
    chk({tag, ".key_valid"}, {7'h0, key_valid}, {7'h0, vld});
    chk({tag, ".data_byte"}, data_byte, dat);
    chk({tag, ".overflow"}, {7'h0, overflow}, {7'h0, ovf});
  endtask

  initial begin
    // Reset values
    repeat (3) tick();
    chk("rst.col_drive", {4'h0, col_drive}, 8'h0E);
    chk_out("rst", 4'h0, 1'b0, 8'h00, 1'b0);
    reset = 1'b1;
    cyc = 0;

    // 1: idle scan, no keys
    for (int i = 0; i < 512; i++) begin
      exp_col = 4'b1111;
      exp_col[(cyc / 8) % 4] = 1'b0;
      chk("scan.col_drive", {4'h0, col_drive}, {4'h0, exp_col});
      if (cyc % 32 == 0) begin
        chk("scan.key_valid", {7'h0, key_valid}, 8'h00);
        chk("scan.data_byte", data_byte, 8'h00);
      end
      tick();
    end

    // 2: key 6 (r1c2) held 4 frames
    pressed = 16'h0040;
    next_frames(2);
    chk("k6.latency", {7'h0, key_valid}, 8'h00);
    next_frames(1);
    chk_out("k6.accept", 4'h6, 1'b1, 8'h06, 1'b0);
    next_frames(1);
    chk_out("k6.once", 4'h6, 1'b1, 8'h06, 1'b0);

    // 3: release, ack, key 7 (r2c0)
    pressed = '0;
    ack();
    chk("k6.ack", {7'h0, key_valid}, 8'h00);
    next_frames(3);
    pressed = 16'h0100;
    next_frames(3);
    chk_out("k7", 4'h7, 1'b1, 8'h67, 1'b0);
    pressed = '0;
    next_frames(3);
    pressed = 16'h8000;
    next_frames(3);
    chk_out("kD.ovf", 4'hD, 1'b1, 8'h7D, 1'b1);
    ack();
    chk_out("kD.ack", 4'hD, 1'b0, 8'h7D, 1'b0);
    pressed = '0;
    next_frames(3);

    // 4: bouncing key 5, then two keys together
    for (int i = 0; i < 5; i++) begin
      pressed = 16'h0020;
      next_frames(1);
      pressed = '0;
      next_frames(1);
    end
    chk_out("bounce", 4'hD, 1'b0, 8'h7D, 1'b0);
    pressed = 16'h0003;
    next_frames(6);
    chk_out("multi", 4'hD, 1'b0, 8'h7D, 1'b0);
    pressed = '0;
    next_frames(1);

    // 5: key A (r0c3) held 20 frames, release debounce
    pressed = 16'h0008;
    next_frames(20);
    chk_out("kA.hold", 4'hA, 1'b1, 8'hDA, 1'b0);
    ack();
    pressed = '0;
    next_frames(2);
    pressed = 16'h0008;
    next_frames(4);
    chk_out("kA.short_rel", 4'hA, 1'b0, 8'hDA, 1'b0);
    pressed = '0;
    next_frames(3);
    pressed = 16'h0008;
    next_frames(2);
    chk("kA.re_lat", {7'h0, key_valid}, 8'h00);
    next_frames(1);
    chk_out("kA.repress", 4'hA, 1'b1, 8'hAA, 1'b0);

    // 6: accept coincident with ack (key 1, r0c0)
    pressed = '0;
    next_frames(3);
    pressed = 16'h0001;
    next_frames(2);
    repeat (31) tick();
    key_ack = 1'b1;
    tick();
    key_ack = 1'b0;
    chk_out("k1.coinc", 4'h1, 1'b1, 8'hA1, 1'b0);

    // 6: reset during PRESS at dc=2 with key 6 held
    pressed = '0;
    next_frames(3);
    pressed = 16'h0040;
    next_frames(2);
    repeat (5) tick();
    reset = 1'b0;
    repeat (2) tick();
    chk("mrst.col_drive", {4'h0, col_drive}, 8'h0E);
    chk_out("mrst", 4'h0, 1'b0, 8'h00, 1'b0);
    reset = 1'b1;
    cyc = 0;
    next_frames(2);
    chk("mrst.latency", {7'h0, key_valid}, 8'h00);
    next_frames(1);
    chk_out("mrst.accept", 4'h6, 1'b1, 8'h06, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
